store_xlate_queue: RTL and testbench
====================================

Name: store_xlate_queue

Overview:
- Parametrised, multi-entry successor to the single-outstanding store unit front end.
- Buffers up to DEPTH store requests in order and translates the head entry through the multi-level TLB interface, waiting as long as the lookup needs.
- Posts translated, data-aligned stores to the store buffer and writes back completion or exception per entry.
- Sits between the LSU issue port and the store buffer / MMU.

Parameters:
- DEPTH, 4: queue entries, power of two, ≥2.
- XLEN, 64: data width, 32 or 64.
- VLEN, 39: virtual address width.
- PLEN, 56: physical address width.
- TRANS_ID_BITS, 3: transaction id width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  kill all queued and in-flight stores
- valid_i  in  1  store request
- ready_o  out  1  queue accepts request
- vaddr_i  in  VLEN  store virtual address
- data_i  in  XLEN  unaligned store data
- be_i  in  XLEN/8  byte enable, already aligned
- size_i  in  2  transfer size (0=B,1=H,2=W,3=D)
- trans_id_i  in  TRANS_ID_BITS  transaction id
- translation_req_o  out  1  translation request for head entry
- vaddr_o  out  VLEN  head entry vaddr
- paddr_i  in  PLEN  translated address
- dtlb_hit_i  in  1  translation valid this cycle
- all_tlbs_checked_i  in  1  multi-level lookup finished this cycle
- ex_valid_i  in  1  translation exception this cycle
- sb_valid_o  out  1  store to store buffer
- sb_ready_i  in  1  store buffer accepts
- sb_paddr_o  out  PLEN  physical address
- sb_data_o  out  XLEN  aligned data
- sb_be_o  out  XLEN/8  byte enable
- sb_size_o  out  2  size
- wb_valid_o  out  1  writeback pulse
- wb_trans_id_o  out  TRANS_ID_BITS  writeback id
- wb_ex_o  out  1  writeback carries exception
- pending_cnt_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_ni low at posedge): queue empty, pointers 0, FSM IDLE, all outputs 0; ready_o=1 from the first cycle after reset.
- Enqueue:
  - Fires on valid_i && ready_o.
  - ready_o = !full; a dequeue in the same cycle does not free a slot for that cycle.
  - Data is aligned on enqueue: data_i << 8*vaddr_i[$clog2(XLEN/8)-1:0].
- Pointers wrap modulo DEPTH. pending_cnt_o is registered and updated by +1, −1 or 0 per cycle.
- Head FSM:
  - IDLE: if queue non-empty, go to XLATE next cycle.
  - XLATE: translation_req_o=1, vaddr_o=head vaddr.
    - ex_valid_i → latch exception flag, go to WB. Exception has priority over hit in the same cycle.
    - Else dtlb_hit_i → register paddr_i, go to POST.
    - Else (including all_tlbs_checked_i=1 with no hit, i.e. walk pending) stay in XLATE with request held.
  - POST:
    - sb_valid_o = !flush_i; fields come from head entry and the registered paddr.
    - sb_valid_o stays high until sb_ready_i. Fields are stable while waiting.
    - On handshake go to WB.
  - WB:
    - wb_valid_o=1 for exactly one cycle, with wb_trans_id_o = head id and wb_ex_o = latched flag.
    - Dequeue head.
    - Next state is XLATE if another entry remains (including one enqueued this cycle), else IDLE.
- Exceptioned entries never assert sb_valid_o.
- Latency, empty queue, hit first try, sb_ready_i=1:
  - Enqueue at cycle N.
  - XLATE at N+1.
  - sb handshake at N+2.
  - wb_valid_o at N+3.
  - Back-to-back throughput: one store per 3 cycles.
- Flush:
  - Next state is reset state except ready_o=1; queue is emptied.
  - Enqueue in the flush cycle is dropped.
  - sb_valid_o is gated low combinationally in the flush cycle.
  - wb_valid_o is suppressed in the flush cycle.
- Outputs are held stable during stalls.
- No behaviour is defined for paddr_i when dtlb_hit_i=0.

Test Plan:
- Reset, single store: vaddr=0x1003, data=0xAB, size=0, hit at first XLATE, sb_ready_i=1 → sb_data_o=0xAB000000, sb_paddr_o=paddr_i, wb_valid_o at N+3 with wb_ex_o=0.
- Fill DEPTH=4 while dtlb_hit_i=0 → ready_o=0 after 4th accept, pending_cnt_o=4; 5th valid_i not accepted. Then hold hit=1 → 4 writebacks in enqueue order, ids 0..3.
- Multi-level miss: all_tlbs_checked_i=0 for 5 cycles, then hit → translation_req_o held 6 cycles, vaddr_o stable, single sb post.
- Exception: ex_valid_i and dtlb_hit_i together in XLATE → no sb_valid_o, wb_valid_o with wb_ex_o=1, next entry proceeds.
- Store-buffer backpressure: sb_ready_i=0 for 3 cycles → sb_valid_o high 4 cycles with constant fields, one writeback.
- Flush with 3 entries and head in POST → sb_valid_o low that cycle, pending_cnt_o=0 and ready_o=1 next cycle, no writeback.

Source files
------------

// File: rtl/store_xlate_queue_if.sv
// Bundles the LSU issue port, MMU lookup, store-buffer and writeback signals of
// the store translation queue. The slave modport is the queue's own view.
interface store_xlate_queue_if #(
   parameter int DEPTH         = 4,
   parameter int XLEN          = 64,
   parameter int VLEN          = 39,
   parameter int PLEN          = 56,
   parameter int TRANS_ID_BITS = 3
);
   logic                       flush_i;
   logic                       valid_i;
   logic                       ready_o;
   logic [VLEN-1:0]            vaddr_i;
   logic [XLEN-1:0]            data_i;
   logic [XLEN/8-1:0]          be_i;
   logic [1:0]                 size_i;
   logic [TRANS_ID_BITS-1:0]   trans_id_i;
   logic                       translation_req_o;
   logic [VLEN-1:0]            vaddr_o;
   logic [PLEN-1:0]            paddr_i;
   logic                       dtlb_hit_i;
   logic                       all_tlbs_checked_i;
   logic                       ex_valid_i;
   logic                       sb_valid_o;
   logic                       sb_ready_i;
   logic [PLEN-1:0]            sb_paddr_o;
   logic [XLEN-1:0]            sb_data_o;
   logic [XLEN/8-1:0]          sb_be_o;
   logic [1:0]                 sb_size_o;
   logic                       wb_valid_o;
   logic [TRANS_ID_BITS-1:0]   wb_trans_id_o;
   logic                       wb_ex_o;
   logic [$clog2(DEPTH):0]     pending_cnt_o;

   modport master (
      output flush_i, valid_i, vaddr_i, data_i, be_i, size_i, trans_id_i,
             paddr_i, dtlb_hit_i, all_tlbs_checked_i, ex_valid_i, sb_ready_i,
      input  ready_o, translation_req_o, vaddr_o, sb_valid_o, sb_paddr_o,
             sb_data_o, sb_be_o, sb_size_o, wb_valid_o, wb_trans_id_o,
             wb_ex_o, pending_cnt_o
   );

   modport slave (
      input  flush_i, valid_i, vaddr_i, data_i, be_i, size_i, trans_id_i,
             paddr_i, dtlb_hit_i, all_tlbs_checked_i, ex_valid_i, sb_ready_i,
      output ready_o, translation_req_o, vaddr_o, sb_valid_o, sb_paddr_o,
             sb_data_o, sb_be_o, sb_size_o, wb_valid_o, wb_trans_id_o,
             wb_ex_o, pending_cnt_o
   );
endinterface

// File: rtl/store_xlate_queue.sv
// In-order store queue: translates the head entry through the TLB, posts it to
// the store buffer, then writes back completion or exception.
//
// state | meaning
// IDLE  | queue empty, nothing to translate
// XLATE | translation request held for head entry until hit or exception
// POST  | head translated, offered to store buffer until accepted
// WB    | one-cycle writeback of head, entry dequeued
module store_xlate_queue #(
   parameter int DEPTH         = 4,
   parameter int XLEN          = 64,
   parameter int VLEN          = 39,
   parameter int PLEN          = 56,
   parameter int TRANS_ID_BITS = 3
) (
   input logic                clk_i,
   input logic                rst_ni,
   store_xlate_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BE_W  = XLEN / 8;
   localparam int OFF_W = $clog2(BE_W);

   typedef enum logic [1:0] {IDLE, XLATE, POST, WB} state_e;
   state_e state_q, state_d;

   logic [VLEN-1:0]          vaddr_mem [DEPTH];
   logic [XLEN-1:0]          data_mem  [DEPTH];
   logic [BE_W-1:0]          be_mem    [DEPTH];
   logic [1:0]               size_mem  [DEPTH];
   logic [TRANS_ID_BITS-1:0] id_mem    [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PLEN-1:0]  paddr_q, paddr_d;
   logic             ex_q, ex_d;
   logic             full, enq, deq;
   logic [XLEN-1:0]  data_aligned;

   assign full         = (cnt_q == CNT_W'(DEPTH));
   assign bus.ready_o  = !full;
   assign enq          = bus.valid_i && !full && !bus.flush_i;
   assign deq          = (state_q == WB) && !bus.flush_i;
   assign data_aligned = bus.data_i << {bus.vaddr_i[OFF_W-1:0], 3'b000};
   assign bus.pending_cnt_o = cnt_q;

   // Payload storage needs no reset: it is only observed through a valid head.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         vaddr_mem[wr_ptr_q] <= bus.vaddr_i;
         data_mem[wr_ptr_q]  <= data_aligned;
         be_mem[wr_ptr_q]    <= bus.be_i;
         size_mem[wr_ptr_q]  <= bus.size_i;
         id_mem[wr_ptr_q]    <= bus.trans_id_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || bus.flush_i) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         paddr_q  <= '0;
         ex_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         paddr_q <= paddr_d;
         ex_q    <= ex_d;
         if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   always_comb begin
      state_d               = state_q;
      paddr_d               = paddr_q;
      ex_d                  = ex_q;
      bus.translation_req_o = 1'b0;
      bus.vaddr_o           = '0;
      bus.sb_valid_o        = 1'b0;
      bus.sb_paddr_o        = '0;
      bus.sb_data_o         = '0;
      bus.sb_be_o           = '0;
      bus.sb_size_o         = '0;
      bus.wb_valid_o        = 1'b0;
      bus.wb_trans_id_o     = '0;
      bus.wb_ex_o           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cnt_q != '0 || enq) state_d = XLATE;
         end
         XLATE: begin
            bus.translation_req_o = 1'b1;
            bus.vaddr_o           = vaddr_mem[rd_ptr_q];
            // Exception wins over a simultaneous hit; a finished walk without
            // a hit keeps the request up.
            if (bus.ex_valid_i) begin
               ex_d    = 1'b1;
               state_d = WB;
            end else if (bus.dtlb_hit_i) begin
               paddr_d = bus.paddr_i;
               state_d = POST;
            end
         end
         POST: begin
            bus.sb_valid_o = !bus.flush_i;
            bus.sb_paddr_o = paddr_q;
            bus.sb_data_o  = data_mem[rd_ptr_q];
            bus.sb_be_o    = be_mem[rd_ptr_q];
            bus.sb_size_o  = size_mem[rd_ptr_q];
            if (!bus.flush_i && bus.sb_ready_i) state_d = WB;
         end
         WB: begin
            bus.wb_valid_o    = !bus.flush_i;
            bus.wb_trans_id_o = id_mem[rd_ptr_q];
            bus.wb_ex_o       = ex_q;
            ex_d              = 1'b0;
            paddr_d           = '0;
            state_d           = (cnt_q > CNT_W'(1) || enq) ? XLATE : IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_store_xlate_queue.sv
// Bench for store_xlate_queue: a queue-of-transactions model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_store_xlate_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 64;
   localparam int VLEN  = 39;
   localparam int PLEN  = 56;
   localparam int TIDW  = 3;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   store_xlate_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN),
                          .TRANS_ID_BITS(TIDW)) bus ();

   store_xlate_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN),
                       .TRANS_ID_BITS(TIDW)) dut (
      .clk_i (clk),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [VLEN-1:0] vaddr;
      logic [XLEN-1:0] data;
      logic [7:0]      be;
      logic [1:0]      size;
      logic [TIDW-1:0] id;
      bit              xl;
      bit              ex;
      bit              posted;
      logic [PLEN-1:0] paddr;
   } ent_t;

   ent_t mq[$];
   int   mcnt = 0;
   int   sb_posts = 0;

   // Model: entries in order; each must be translated, then posted (unless
   // exceptioned), then written back exactly once.
   always @(negedge clk) begin
      ent_t e;
      bit   ok;
      if (!rst_ni) begin
         mq.delete();
         mcnt = 0;
      end else begin
         chk("pending", 64'(bus.pending_cnt_o), 64'(mcnt));
         chk("ready", 64'(bus.ready_o), 64'(mcnt < DEPTH));
         if (bus.translation_req_o) begin
            ok = (mq.size() > 0) && !mq[0].xl;
            chk("xreq_legal", 64'(ok), 64'd1);
            if (mq.size() > 0) chk("xreq_vaddr", 64'(bus.vaddr_o), 64'(mq[0].vaddr));
         end
         if (bus.sb_valid_o) begin
            ok = (mq.size() > 0) && mq[0].xl && !mq[0].ex && !mq[0].posted;
            chk("sb_legal", 64'(ok), 64'd1);
            if (mq.size() > 0) begin
               chk("sb_paddr", 64'(bus.sb_paddr_o), 64'(mq[0].paddr));
               chk("sb_data", bus.sb_data_o, mq[0].data);
               chk("sb_be", 64'(bus.sb_be_o), 64'(mq[0].be));
               chk("sb_size", 64'(bus.sb_size_o), 64'(mq[0].size));
            end
         end
         if (bus.wb_valid_o) begin
            ok = (mq.size() > 0) && mq[0].xl && (mq[0].ex || mq[0].posted);
            chk("wb_legal", 64'(ok), 64'd1);
            if (mq.size() > 0) begin
               chk("wb_id", 64'(bus.wb_trans_id_o), 64'(mq[0].id));
               chk("wb_ex", 64'(bus.wb_ex_o), 64'(mq[0].ex));
            end
         end
         if (bus.flush_i) begin
            mq.delete();
            mcnt = 0;
         end else begin
            ok = bus.valid_i && (mcnt < DEPTH);
            if (mq.size() > 0 && bus.translation_req_o && (bus.ex_valid_i || bus.dtlb_hit_i)) begin
               e = mq[0];
               e.xl = 1'b1;
               e.ex = bus.ex_valid_i;
               e.paddr = bus.paddr_i;
               mq[0] = e;
            end
            if (mq.size() > 0 && bus.sb_valid_o && bus.sb_ready_i) begin
               e = mq[0];
               e.posted = 1'b1;
               mq[0] = e;
               sb_posts++;
            end
            if (mq.size() > 0 && bus.wb_valid_o) begin
               void'(mq.pop_front());
               mcnt--;
            end
            if (ok) begin
               e.vaddr  = bus.vaddr_i;
               e.data   = bus.data_i << (8 * (bus.vaddr_i % (XLEN / 8)));
               e.be     = bus.be_i;
               e.size   = bus.size_i;
               e.id     = bus.trans_id_i;
               e.xl     = 1'b0;
               e.ex     = 1'b0;
               e.posted = 1'b0;
               e.paddr  = '0;
               mq.push_back(e);
               mcnt++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic put(input logic [VLEN-1:0] va, input logic [XLEN-1:0] d,
                      input logic [7:0] be, input logic [1:0] sz, input logic [TIDW-1:0] id);
      bus.valid_i    = 1'b1;
      bus.vaddr_i    = va;
      bus.data_i     = d;
      bus.be_i       = be;
      bus.size_i     = sz;
      bus.trans_id_i = id;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int posts0;
      logic [TIDW-1:0] ids [8];

      bus.flush_i = 0; bus.valid_i = 0; bus.vaddr_i = '0; bus.data_i = '0;
      bus.be_i = '0; bus.size_i = '0; bus.trans_id_i = '0; bus.paddr_i = '0;
      bus.dtlb_hit_i = 0; bus.all_tlbs_checked_i = 0; bus.ex_valid_i = 0;
      bus.sb_ready_i = 1;
      repeat (3) @(posedge clk);
      #1 rst_ni = 1'b1;

      mid();
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      chk("rst_pending", 64'(bus.pending_cnt_o), 64'd0);
      chk("rst_req", 64'(bus.translation_req_o), 64'd0);
      chk("rst_sb", 64'(bus.sb_valid_o), 64'd0);
      chk("rst_wb", 64'(bus.wb_valid_o), 64'd0);

      // single store, latency N+1 / N+2 / N+3
      step();
      put(39'h1003, 64'hAB, 8'h08, 2'd0, 3'd0);
      bus.dtlb_hit_i = 1; bus.paddr_i = 56'h8000_1003;
      mid(); chk("t1_req_n", 64'(bus.translation_req_o), 64'd0);
      step(); bus.valid_i = 0;
      mid();
      chk("t1_req", 64'(bus.translation_req_o), 64'd1);
      chk("t1_vaddr", 64'(bus.vaddr_o), 64'h1003);
      step(); mid();
      chk("t1_sb_valid", 64'(bus.sb_valid_o), 64'd1);
      chk("t1_sb_data", bus.sb_data_o, 64'hAB00_0000);
      chk("t1_sb_paddr", 64'(bus.sb_paddr_o), 64'h8000_1003);
      chk("t1_wb_early", 64'(bus.wb_valid_o), 64'd0);
      step(); mid();
      chk("t1_wb", 64'(bus.wb_valid_o), 64'd1);
      chk("t1_wb_id", 64'(bus.wb_trans_id_o), 64'd0);
      chk("t1_wb_ex", 64'(bus.wb_ex_o), 64'd0);
      step(); mid();
      chk("t1_wb_once", 64'(bus.wb_valid_o), 64'd0);
      chk("t1_pending", 64'(bus.pending_cnt_o), 64'd0);

      // fill while TLB misses, then drain in order
      bus.dtlb_hit_i = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         put(39'h2000 + 39'(8 * i), 64'h1111 * 64'(i + 1), 8'hFF, 2'd3, 3'(i));
      end
      mid(); chk("t2_ready_3", 64'(bus.ready_o), 64'd1);
      step(); put(39'h2100, 64'h9999, 8'hFF, 2'd3, 3'd4);
      mid();
      chk("t2_ready_full", 64'(bus.ready_o), 64'd0);
      chk("t2_pending_4", 64'(bus.pending_cnt_o), 64'd4);
      step(); bus.valid_i = 0;
      mid(); chk("t2_no_5th", 64'(bus.pending_cnt_o), 64'd4);
      step(); bus.dtlb_hit_i = 1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         bus.paddr_i = 56'h9000 + 56'(k * 16);
         mid();
         if (bus.wb_valid_o && n < 8) begin ids[n] = bus.wb_trans_id_o; n++; end
         step();
      end
      chk("t2_wb_count", 64'(n), 64'd4);
      for (int i = 0; i < 4; i++) chk("t2_wb_order", 64'(ids[i]), 64'(i));

      // multi-level walk: six request cycles, one post
      bus.dtlb_hit_i = 0; bus.all_tlbs_checked_i = 0;
      posts0 = sb_posts;
      step(); put(39'h3006, 64'h1234, 8'hC0, 2'd1, 3'd5);
      step(); bus.valid_i = 0;
      for (int k = 1; k <= 5; k++) begin
         mid();
         chk("t3_req_held", 64'(bus.translation_req_o), 64'd1);
         chk("t3_vaddr", 64'(bus.vaddr_o), 64'h3006);
         step();
         bus.all_tlbs_checked_i = (k >= 3);
      end
      bus.dtlb_hit_i = 1; bus.paddr_i = 56'hABC000;
      mid(); chk("t3_req_6", 64'(bus.translation_req_o), 64'd1);
      step(); bus.dtlb_hit_i = 0; bus.all_tlbs_checked_i = 0; bus.paddr_i = '0;
      mid();
      chk("t3_sb_valid", 64'(bus.sb_valid_o), 64'd1);
      chk("t3_sb_data", bus.sb_data_o, 64'h1234_0000_0000_0000);
      chk("t3_sb_paddr", 64'(bus.sb_paddr_o), 64'hABC000);
      step(); mid();
      chk("t3_wb_id", 64'(bus.wb_trans_id_o), 64'd5);
      step();
      chk("t3_posts", 64'(sb_posts - posts0), 64'd1);

      // exception beats a simultaneous hit; next entry still completes
      step(); put(39'h4000, 64'h55, 8'h01, 2'd0, 3'd1);
      mid();
      step(); put(39'h4008, 64'h66, 8'h01, 2'd0, 3'd2);
      bus.ex_valid_i = 1; bus.dtlb_hit_i = 1; bus.paddr_i = 56'h7000;
      mid(); chk("t4_vaddr_a", 64'(bus.vaddr_o), 64'h4000);
      step(); bus.valid_i = 0; bus.ex_valid_i = 0;
      mid();
      chk("t4_wb_ex", 64'(bus.wb_ex_o), 64'd1);
      chk("t4_wb_id", 64'(bus.wb_trans_id_o), 64'd1);
      chk("t4_wb_valid", 64'(bus.wb_valid_o), 64'd1);
      chk("t4_no_sb", 64'(bus.sb_valid_o), 64'd0);
      step(); mid(); chk("t4_vaddr_b", 64'(bus.vaddr_o), 64'h4008);
      step(); mid(); chk("t4_sb_b", 64'(bus.sb_paddr_o), 64'h7000);
      step(); mid();
      chk("t4_wb_b_id", 64'(bus.wb_trans_id_o), 64'd2);
      chk("t4_wb_b_ex", 64'(bus.wb_ex_o), 64'd0);

      // store-buffer backpressure
      bus.sb_ready_i = 0; bus.paddr_i = 56'h5A5A0;
      posts0 = sb_posts;
      step(); put(39'h5001, 64'h77, 8'h02, 2'd0, 3'd6);
      step(); bus.valid_i = 0;
      step(); bus.paddr_i = 56'hFFFF;
      for (int k = 0; k < 3; k++) begin
         mid();
         chk("t5_sb_held", 64'(bus.sb_valid_o), 64'd1);
         chk("t5_paddr", 64'(bus.sb_paddr_o), 64'h5A5A0);
         chk("t5_data", bus.sb_data_o, 64'h7700);
         step();
      end
      bus.sb_ready_i = 1;
      mid(); chk("t5_sb_4th", 64'(bus.sb_valid_o), 64'd1);
      step(); mid();
      chk("t5_wb", 64'(bus.wb_valid_o), 64'd1);
      chk("t5_sb_done", 64'(bus.sb_valid_o), 64'd0);
      chk("t5_posts", 64'(sb_posts - posts0), 64'd1);

      // flush with three entries, head stalled in POST
      bus.sb_ready_i = 0; bus.paddr_i = 56'h123;
      for (int i = 0; i < 3; i++) begin
         step();
         put(39'h6000 + 39'(8 * i), 64'(i + 1), 8'hFF, 2'd3, 3'(i));
      end
      step(); put(39'h6100, 64'h7, 8'hFF, 2'd3, 3'd7);
      bus.flush_i = 1;
      mid();
      chk("t6_sb_gated", 64'(bus.sb_valid_o), 64'd0);
      chk("t6_wb_none", 64'(bus.wb_valid_o), 64'd0);
      chk("t6_pending_3", 64'(bus.pending_cnt_o), 64'd3);
      step(); bus.flush_i = 0; bus.valid_i = 0; bus.sb_ready_i = 1;
      mid();
      chk("t6_pending_0", 64'(bus.pending_cnt_o), 64'd0);
      chk("t6_ready", 64'(bus.ready_o), 64'd1);
      chk("t6_req_idle", 64'(bus.translation_req_o), 64'd0);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         step(); mid();
         if (bus.wb_valid_o || bus.sb_valid_o) n++;
      end
      chk("t6_quiet", 64'(n), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
